// File: rtl/match_sequencer_if.sv
// Bundles the frame tick, start buttons, stock counts and overlay/control outputs
// exchanged between the match sequencer and the rest of the game datapath.
interface match_sequencer_if;
    logic       frame_tick;
    logic       start_btn1;
    logic       start_btn2;
    logic [1:0] stocks1;
    logic [1:0] stocks2;
    logic       match_reset;
    logic       input_enable;
    logic       game_frame_tick;
    logic [2:0] game_state;
    logic [1:0] countdown_digit;
    logic [1:0] winner;

    // Sequencer side
    modport slave (
        input  frame_tick, start_btn1, start_btn2, stocks1, stocks2,
        output match_reset, input_enable, game_frame_tick, game_state,
               countdown_digit, winner
    );

    // Surrounding game logic side
    modport master (
        output frame_tick, start_btn1, start_btn2, stocks1, stocks2,
        input  match_reset, input_enable, game_frame_tick, game_state,
               countdown_digit, winner
    );
endinterface

// File: rtl/match_sequencer.sv
// Game-flow controller: ATTRACT -> COUNTDOWN -> FIGHT (<-> PAUSED) -> RESULT -> ATTRACT.
// Issues the match reset pulse, gates frame tick and input, and picks the winner.
module match_sequencer #(
    parameter int unsigned COUNTDOWN_FRAMES = 180,
    parameter int unsigned RESULT_FRAMES    = 300,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             reset,
    match_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_ATTRACT   = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_FIGHT     = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_RESULT    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CD_LOAD    = CNT_W'(COUNTDOWN_FRAMES);
    localparam logic [CNT_W-1:0] CD_THIRD   = CNT_W'(COUNTDOWN_FRAMES / 3);
    localparam logic [CNT_W-1:0] CD_TWO_3RD = CNT_W'((2 * COUNTDOWN_FRAMES) / 3);
    localparam logic [CNT_W-1:0] RES_LOAD   = CNT_W'(RESULT_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_winner;
    logic             r_match_reset;
    logic             r_prev1;
    logic             r_prev2;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_winner_nxt;
    logic             w_match_reset_nxt;
    logic             w_start_rise;
    logic             w_out1;
    logic             w_out2;
    logic [1:0]       w_digit;

    assign w_start_rise = (bus.start_btn1 & ~r_prev1) | (bus.start_btn2 & ~r_prev2);
    assign w_out1       = (bus.stocks1 == 2'd0);
    assign w_out2       = (bus.stocks2 == 2'd0);

    // State register. History regs reset high so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
        if (reset) begin
            r_state       <= ST_ATTRACT;
            r_cnt         <= CNT_ZERO;
            r_winner      <= 2'b00;
            r_match_reset <= 1'b0;
            r_prev1       <= 1'b1;
            r_prev2       <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_winner      <= w_winner_nxt;
            r_match_reset <= w_match_reset_nxt;
            r_prev1       <= bus.start_btn1;
            r_prev2       <= bus.start_btn2;
        end
    end

    // Next-state, counter and winner logic.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_winner_nxt      = r_winner;
        w_match_reset_nxt = 1'b0;

        case (r_state)
            ST_ATTRACT: begin
                if (w_start_rise) begin
                    w_match_reset_nxt = 1'b1;
                    w_winner_nxt      = 2'b00;
                    w_cnt_nxt         = CD_LOAD;
                    w_state_nxt       = ST_COUNTDOWN;
                end
            end

            ST_COUNTDOWN: begin
                if (bus.frame_tick) begin
                    if (r_cnt > CNT_ONE) begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end else begin
                        w_cnt_nxt   = CNT_ZERO;
                        w_state_nxt = ST_FIGHT;
                    end
                end
            end

            ST_FIGHT: begin
                // A knockout outranks a pause request arriving in the same cycle.
                if (w_out1 || w_out2) begin
                    w_winner_nxt = {w_out1, w_out2};
                    w_cnt_nxt    = RES_LOAD;
                    w_state_nxt  = ST_RESULT;
                end else if (w_start_rise) begin
                    w_state_nxt = ST_PAUSED;
                end
            end

            ST_PAUSED: begin
                if (w_start_rise) begin
                    w_state_nxt = ST_FIGHT;
                end
            end

            ST_RESULT: begin
                if (bus.frame_tick) begin
                    if (r_cnt > CNT_ONE) begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end else begin
                        w_cnt_nxt   = CNT_ZERO;
                        w_state_nxt = ST_ATTRACT;
                    end
                end
            end

            default: begin
                w_cnt_nxt   = CNT_ZERO;
                w_state_nxt = ST_ATTRACT;
            end
        endcase
    end

    // Output decode from the registered state and counter.
    always_comb begin
        w_digit = 2'd0;
        if (r_state == ST_COUNTDOWN) begin
            if (r_cnt > CD_TWO_3RD) begin
                w_digit = 2'd3;
            end else if (r_cnt > CD_THIRD) begin
                w_digit = 2'd2;
            end else if (r_cnt != CNT_ZERO) begin
                w_digit = 2'd1;
            end
        end
    end

    assign bus.game_state      = r_state;
    assign bus.input_enable    = (r_state == ST_FIGHT);
    assign bus.game_frame_tick = bus.frame_tick & (r_state == ST_FIGHT);
    assign bus.countdown_digit = w_digit;
    assign bus.winner          = r_winner;
    assign bus.match_reset     = r_match_reset;

endmodule
